// File: rtl/uart_frame_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_frame_pkg                                                   |
// | Frame constants and RX state encoding shared by the UART frame   |
// | streamer (TX) and frame assembler (RX).                          |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
package uart_frame_pkg;

    localparam logic [7:0] HEADER_BYTE  = 8'hAA;
    localparam int         FRAME_WIDTH  = 176;
    localparam int         FRAME_HEIGHT = 240;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_HUNT       = 3'd1,
        ST_R          = 3'd2,
        ST_G          = 3'd3,
        ST_B          = 3'd4,
        ST_WRITE      = 3'd5,
        ST_FRAME_DONE = 3'd6
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_rx_frame_fsm.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_rx_frame_fsm                                                |
// | Pops UART RX bytes, locks onto the frame header and writes packed|
// | {R,G,B} pixels to consecutive frame-buffer addresses.            |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module uart_rx_frame_fsm #(
    parameter int                    DATA_WIDTH     = 8,
    parameter int                    TOTAL_PIXELS   = uart_frame_pkg::FRAME_WIDTH * uart_frame_pkg::FRAME_HEIGHT,
    parameter int                    ADDR_WIDTH     = $clog2(TOTAL_PIXELS),
    parameter logic [DATA_WIDTH-1:0] HEADER_BYTE    = uart_frame_pkg::HEADER_BYTE,
    parameter int                    TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    rx_en,
    input  logic                    rx_fifo_empty,
    input  logic [DATA_WIDTH-1:0]   rx_fifo_rdata,
    output logic                    rx_fifo_pop,
    output logic [ADDR_WIDTH-1:0]   wAddr,
    output logic [DATA_WIDTH*3-1:0] wData,
    output logic                    we,
    output logic                    busy,
    output logic                    pixel_done,
    output logic                    frame_done,
    output logic                    frame_err
);
    import uart_frame_pkg::*;

    localparam int                    CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]      TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(TOTAL_PIXELS - 1);

    rx_state_t                 state_q, state_d;
    logic                      pop_q, pop_d;
    logic [ADDR_WIDTH-1:0]     waddr_q, waddr_d;
    logic [DATA_WIDTH*3-1:0]   wdata_q, wdata_d;
    logic                      we_q, we_d;
    logic                      busy_q, busy_d;
    logic                      pixel_done_q, pixel_done_d;
    logic                      frame_done_q, frame_done_d;
    logic                      frame_err_q, frame_err_d;
    logic [DATA_WIDTH-1:0]     r_q, r_d, g_q, g_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      accept;
    logic [CNT_W-1:0]          cnt_inc;

    // The registered pop blocks a second accept until the FIFO head has advanced.
    always_comb begin
        accept = 1'b0;
        if (state_q == ST_HUNT || state_q == ST_R || state_q == ST_G || state_q == ST_B)
            accept = !rx_fifo_empty && !pop_q;
    end

    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        state_d      = state_q;
        pop_d        = accept;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        we_d         = 1'b0;
        busy_d       = busy_q;
        pixel_done_d = 1'b0;
        frame_done_d = 1'b0;
        frame_err_d  = 1'b0;
        r_d          = r_q;
        g_d          = g_q;
        cnt_d        = cnt_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (rx_en)
                    state_d = ST_HUNT;
            end
            ST_HUNT: begin
                cnt_d = '0;
                if (accept) begin
                    if (rx_fifo_rdata == HEADER_BYTE) begin
                        waddr_d = '0;
                        busy_d  = 1'b1;
                        state_d = ST_R;
                    end
                end else if (!rx_en) begin
                    state_d = ST_IDLE;
                end
            end
            ST_R, ST_G, ST_B: begin
                if (accept) begin
                    cnt_d = '0;
                    if (state_q == ST_R) begin
                        r_d     = rx_fifo_rdata;
                        state_d = ST_G;
                    end else if (state_q == ST_G) begin
                        g_d     = rx_fifo_rdata;
                        state_d = ST_B;
                    end else begin
                        wdata_d      = {r_q, g_q, rx_fifo_rdata};
                        we_d         = 1'b1;
                        pixel_done_d = 1'b1;
                        state_d      = ST_WRITE;
                    end
                end else if (cnt_inc == TO_LAST) begin
                    // Abort lands on the edge the counter would reach its limit.
                    cnt_d       = '0;
                    frame_err_d = 1'b1;
                    waddr_d     = '0;
                    busy_d      = 1'b0;
                    state_d     = ST_HUNT;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_WRITE: begin
                if (waddr_q == LAST_ADDR) begin
                    waddr_d      = '0;
                    frame_done_d = 1'b1;
                    state_d      = ST_FRAME_DONE;
                end else begin
                    waddr_d = waddr_q + ADDR_WIDTH'(1);
                    state_d = ST_R;
                end
            end
            ST_FRAME_DONE: begin
                busy_d  = 1'b0;
                state_d = rx_en ? ST_HUNT : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            pop_q        <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            busy_q       <= 1'b0;
            pixel_done_q <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            r_q          <= '0;
            g_q          <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            pop_q        <= pop_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            we_q         <= we_d;
            busy_q       <= busy_d;
            pixel_done_q <= pixel_done_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
            r_q          <= r_d;
            g_q          <= g_d;
            cnt_q        <= cnt_d;
        end
    end

    assign rx_fifo_pop = pop_q;
    assign wAddr       = waddr_q;
    assign wData       = wdata_q;
    assign we          = we_q;
    assign busy        = busy_q;
    assign pixel_done  = pixel_done_q;
    assign frame_done  = frame_done_q;
    assign frame_err   = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_frame_fsm.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_uart_rx_frame_fsm                                             |
// | Scoreboard bench: FIFO model feeds bytes, expected pixel writes  |
// | are queued as bytes are pushed and compared on each write strobe.|
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module tb_uart_rx_frame_fsm;

    localparam int C_PIX = 3;
    localparam int C_TO  = 50;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx_en = 1'b0;
    logic        rx_fifo_empty = 1'b1;
    logic [7:0]  rx_fifo_rdata = 8'h00;
    logic        rx_fifo_pop;
    logic [1:0]  wAddr;
    logic [23:0] wData;
    logic        we, busy, pixel_done, frame_done, frame_err;

    uart_rx_frame_fsm #(
        .DATA_WIDTH    (8),
        .TOTAL_PIXELS  (C_PIX),
        .TIMEOUT_CYCLES(C_TO)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .rx_en        (rx_en),
        .rx_fifo_empty(rx_fifo_empty),
        .rx_fifo_rdata(rx_fifo_rdata),
        .rx_fifo_pop  (rx_fifo_pop),
        .wAddr        (wAddr),
        .wData        (wData),
        .we           (we),
        .busy         (busy),
        .pixel_done   (pixel_done),
        .frame_done   (frame_done),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    logic [7:0]  fifo_q[$];
    logic [25:0] exp_q[$];
    int          we_cyc[$];
    int          n_checks = 0, n_errors = 0;
    int          cycle = 0, pop_cnt = 0, pop_b2b = 0, we_cnt = 0, pd_cnt = 0;
    int          frame_cnt = 0, err_cnt = 0, fd_cycle = 0, err_cycle = 0, last_pop_cycle = 0;
    logic        prev_pop = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    // One cycle: observe outputs mid-cycle, model the FWFT FIFO, refresh its head.
    task automatic tick();
        logic [25:0] e;
        @(negedge clk);
        cycle++;
        if (rx_fifo_pop) begin
            if (fifo_q.size() > 0) void'(fifo_q.pop_front());
            pop_cnt++;
            last_pop_cycle = cycle;
            if (prev_pop) pop_b2b++;
        end
        prev_pop = rx_fifo_pop;
        if (we) begin
            we_cnt++;
            we_cyc.push_back(cycle);
            if (exp_q.size() == 0) begin
                check("unexpected_we", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("waddr", {30'd0, wAddr}, {30'd0, e[25:24]});
                check("wdata", {8'd0, wData}, {8'd0, e[23:0]});
            end
        end
        if (pixel_done) pd_cnt++;
        if (frame_done) begin frame_cnt++; fd_cycle = cycle; end
        if (frame_err)  begin err_cnt++;   err_cycle = cycle; end
        rx_fifo_empty = (fifo_q.size() == 0);
        rx_fifo_rdata = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
    endtask

    task automatic push_pixel(input logic [1:0] addr, input logic [23:0] px);
        fifo_q.push_back(px[23:16]);
        fifo_q.push_back(px[15:8]);
        fifo_q.push_back(px[7:0]);
        exp_q.push_back({addr, px});
    endtask

    task automatic wait_frame(input string tag, input int limit);
        int start;
        int n;
        start = frame_cnt;
        n = 0;
        while (frame_cnt == start && n < limit) begin tick(); n++; end
        check(tag, {31'd0, frame_cnt != start}, 32'd1);
        repeat (3) tick();
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_pop"},  {31'd0, rx_fifo_pop}, 32'd0);
        check({tag, "_addr"}, {30'd0, wAddr},       32'd0);
        check({tag, "_data"}, {8'd0, wData},        32'd0);
        check({tag, "_we"},   {31'd0, we},          32'd0);
        check({tag, "_busy"}, {31'd0, busy},        32'd0);
        check({tag, "_strb"}, {29'd0, pixel_done, frame_done, frame_err}, 32'd0);
    endtask

    initial begin
        int p0, n;
        repeat (3) tick();
        check_idle_outputs("reset");
        reset = 1'b0;
        tick();
        check_idle_outputs("idle_no_en");

        // Nominal frame with back-to-back availability.
        rx_en = 1'b1;
        we_cyc.delete();
        p0 = pop_cnt;
        fifo_q.push_back(8'hAA);
        push_pixel(2'd0, 24'h102030);
        push_pixel(2'd1, 24'h405060);
        push_pixel(2'd2, 24'h708090);
        tick();
        tick();
        check("busy_after_hdr", {31'd0, busy}, 32'd1);
        wait_frame("nominal_frame", 200);
        check("nominal_pops", pop_cnt - p0, 32'd10);
        check("nominal_we_cnt", we_cyc.size(), 32'd3);
        if (we_cyc.size() == 3) begin
            check("pix_interval0", we_cyc[1] - we_cyc[0], 32'd6);
            check("pix_interval1", we_cyc[2] - we_cyc[1], 32'd6);
            check("frame_done_lat", fd_cycle - we_cyc[2], 32'd1);
        end
        check("busy_after_frame", {31'd0, busy}, 32'd0);

        // Header hunt: leading garbage is popped and dropped.
        p0 = pop_cnt;
        fifo_q.push_back(8'h00);
        fifo_q.push_back(8'h55);
        fifo_q.push_back(8'hFF);
        fifo_q.push_back(8'hAA);
        push_pixel(2'd0, 24'h010203);
        push_pixel(2'd1, 24'h040506);
        push_pixel(2'd2, 24'h070809);
        wait_frame("hunt_frame", 200);
        check("hunt_pops", pop_cnt - p0, 32'd13);

        // Header value inside payload is pixel data.
        n = frame_cnt;
        fifo_q.push_back(8'hAA);
        push_pixel(2'd0, 24'hAAAAAA);
        push_pixel(2'd1, 24'h112233);
        push_pixel(2'd2, 24'h445566);
        wait_frame("payload_aa_frame", 200);
        check("payload_aa_one_frame", frame_cnt - n, 32'd1);

        // Timeout after R,G with nothing more arriving.
        n = we_cnt;
        p0 = err_cnt;
        fifo_q.push_back(8'hAA);
        fifo_q.push_back(8'h01);
        fifo_q.push_back(8'h02);
        n = we_cnt;
        begin
            int k;
            k = 0;
            while (err_cnt == p0 && k < 200) begin tick(); k++; end
        end
        check("timeout_seen", err_cnt - p0, 32'd1);
        check("timeout_latency", err_cycle - last_pop_cycle, 32'd49);
        check("timeout_no_we", we_cnt - n, 32'd0);
        check("timeout_addr", {30'd0, wAddr}, 32'd0);
        check("timeout_busy", {31'd0, busy}, 32'd0);
        fifo_q.push_back(8'h33);
        fifo_q.push_back(8'hAA);
        push_pixel(2'd0, 24'hC0FFEE);
        push_pixel(2'd1, 24'h123456);
        push_pixel(2'd2, 24'h789ABC);
        wait_frame("after_timeout_frame", 200);

        // Reset mid-frame after the G byte of the second pixel.
        p0 = pop_cnt;
        fifo_q.push_back(8'hAA);
        push_pixel(2'd0, 24'hDEADBE);
        fifo_q.push_back(8'h21);
        fifo_q.push_back(8'h22);
        begin
            int k;
            k = 0;
            while (pop_cnt - p0 < 6 && k < 100) begin tick(); k++; end
            check("pre_reset_pops", pop_cnt - p0, 32'd6);
        end
        tick();
        reset = 1'b1;
        tick();
        check_idle_outputs("mid_reset");
        reset = 1'b0;
        fifo_q.push_back(8'h12);
        fifo_q.push_back(8'h34);
        fifo_q.push_back(8'hAA);
        push_pixel(2'd0, 24'h010203);
        push_pixel(2'd1, 24'h040506);
        push_pixel(2'd2, 24'h070809);
        wait_frame("post_reset_frame", 200);

        check("no_b2b_pops", pop_b2b, 32'd0);
        check("pixel_done_eq_we", pd_cnt, we_cnt);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        check("frame_count", frame_cnt, 32'd5);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
